// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX stage.
//   XLEN_DEFAULT  default datapath width
//   REG_X0        hardwired-zero register index
//   alu_op_e      4-bit ALU operation encoding
//   id_ex_t       one ID/EX pipeline register entry; ID_EX_BUBBLE is the empty entry
//   wb_hit        true when the WB write port targets a given source register
package pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [4:0]  REG_X0       = 5'd0;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluLui   = 4'd10,
        AluPassB = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic                    valid;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic [XLEN_DEFAULT-1:0] op1;
        logic [XLEN_DEFAULT-1:0] op2;
        logic [XLEN_DEFAULT-1:0] imm;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    alu_src;
        alu_op_e                 alu_op;
    } id_ex_t;

    // All-zero entry: not valid and writes nothing, so forwarding/hazard logic ignore it.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic wb_hit(input logic reg_write_wb, input logic [4:0] rd_wb,
                                    input logic [4:0] rs);
        return reg_write_wb && (rd_wb != REG_X0) && (rd_wb == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, write-back and the ID/EX stage.
//   master: drives ID fields, WB write port and flushEx; observes EX outputs
//   slave : the ID/EX stage itself
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    // ID side
    logic            validId;
    logic [XLEN-1:0] pcId;
    logic [4:0]      rs1Id, rs2Id, rdId;
    logic            useRs1Id, useRs2Id;
    logic [XLEN-1:0] rdata1Id, rdata2Id, immId;
    logic            regWriteId, memReadId, memWriteId, aluSrcId;
    logic [3:0]      aluOpId;
    // WB write port and EX redirect
    logic [4:0]      rdWb;
    logic            regWriteWb;
    logic [XLEN-1:0] wbData;
    logic            flushEx;
    // Stage outputs
    logic            stallIf;
    logic            validEx;
    logic [XLEN-1:0] pcEx;
    logic [4:0]      rs1Ex, rs2Ex, rdEx;
    logic [XLEN-1:0] op1Ex, op2Ex, immEx;
    logic            regWriteEx, memReadEx, memWriteEx, aluSrcEx;
    logic [3:0]      aluOpEx;
    logic [CNT_W-1:0] stallCount;

    modport master (
        output validId, pcId, rs1Id, rs2Id, rdId, useRs1Id, useRs2Id, rdata1Id, rdata2Id,
               immId, regWriteId, memReadId, memWriteId, aluSrcId, aluOpId,
               rdWb, regWriteWb, wbData, flushEx,
        input  stallIf, validEx, pcEx, rs1Ex, rs2Ex, rdEx, op1Ex, op2Ex, immEx,
               regWriteEx, memReadEx, memWriteEx, aluSrcEx, aluOpEx, stallCount
    );

    modport slave (
        input  validId, pcId, rs1Id, rs2Id, rdId, useRs1Id, useRs2Id, rdata1Id, rdata2Id,
               immId, regWriteId, memReadId, memWriteId, aluSrcId, aluOpId,
               rdWb, regWriteWb, wbData, flushEx,
        output stallIf, validEx, pcEx, rs1Ex, rs2Ex, rdEx, op1Ex, op2Ex, immEx,
               regWriteEx, memReadEx, memWriteEx, aluSrcEx, aluOpEx, stallCount
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector.
//   valid_ex_i, mem_read_ex_i, rd_ex_i : load currently in EX
//   valid_id_i, rs*_id_i, use_rs*_id_i : source operands of the ID instruction
//   load_use_o                         : ID instruction needs the load result too early
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       valid_ex_i,
    input  logic       mem_read_ex_i,
    input  logic [4:0] rd_ex_i,
    input  logic       valid_id_i,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic       use_rs1_id_i,
    input  logic       use_rs2_id_i,
    output logic       load_use_o
);

    always_comb begin
        load_use_o = valid_ex_i & mem_read_ex_i & (rd_ex_i != REG_X0) & valid_id_i &
                     ((use_rs1_id_i & (rd_ex_i == rs1_id_i)) |
                      (use_rs2_id_i & (rd_ex_i == rs2_id_i)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, EX flush and WB->ID bypass.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ID inputs, WB write port, flushEx in; registered EX fields, stallIf and
//                saturating load-use stall counter out
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    id_ex_t           ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic             stall;
    logic [XLEN-1:0]  op1_byp, op2_byp;

    hazard_detect u_hazard_detect (
        .valid_ex_i    (ex_q.valid),
        .mem_read_ex_i (ex_q.mem_read),
        .rd_ex_i       (ex_q.rd),
        .valid_id_i    (bus.validId),
        .rs1_id_i      (bus.rs1Id),
        .rs2_id_i      (bus.rs2Id),
        .use_rs1_id_i  (bus.useRs1Id),
        .use_rs2_id_i  (bus.useRs2Id),
        .load_use_o    (load_use)
    );

    always_comb begin
        // Register file writes and reads in the same cycle: take the value being written.
        op1_byp = wb_hit(bus.regWriteWb, bus.rdWb, bus.rs1Id) ? bus.wbData : bus.rdata1Id;
        op2_byp = wb_hit(bus.regWriteWb, bus.rdWb, bus.rs2Id) ? bus.wbData : bus.rdata2Id;

        // A flush discards the ID instruction, so holding it upstream would be pointless.
        stall = load_use & ~bus.flushEx & rst_n;

        ex_d        = ID_EX_BUBBLE;
        stall_cnt_d = stall_cnt_q;
        if (bus.flushEx) begin
            ex_d = ID_EX_BUBBLE;
        end else if (load_use) begin
            ex_d = ID_EX_BUBBLE;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else begin
            ex_d.valid     = bus.validId;
            ex_d.pc        = bus.pcId;
            ex_d.rs1       = bus.rs1Id;
            ex_d.rs2       = bus.rs2Id;
            ex_d.rd        = bus.rdId;
            ex_d.op1       = op1_byp;
            ex_d.op2       = op2_byp;
            ex_d.imm       = bus.immId;
            ex_d.reg_write = bus.validId & bus.regWriteId;
            ex_d.mem_read  = bus.validId & bus.memReadId;
            ex_d.mem_write = bus.validId & bus.memWriteId;
            ex_d.alu_src   = bus.aluSrcId;
            ex_d.alu_op    = alu_op_e'(bus.aluOpId);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= ID_EX_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        bus.stallIf    = stall;
        bus.validEx    = ex_q.valid;
        bus.pcEx       = ex_q.pc;
        bus.rs1Ex      = ex_q.rs1;
        bus.rs2Ex      = ex_q.rs2;
        bus.rdEx       = ex_q.rd;
        bus.op1Ex      = ex_q.op1;
        bus.op2Ex      = ex_q.op2;
        bus.immEx      = ex_q.imm;
        bus.regWriteEx = ex_q.reg_write;
        bus.memReadEx  = ex_q.mem_read;
        bus.memWriteEx = ex_q.mem_write;
        bus.aluSrcEx   = ex_q.alu_src;
        bus.aluOpEx    = ex_q.alu_op;
        bus.stallCount = stall_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst_n;
        logic        validId;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] rd1, rd2, imm;
        logic        rw, mr, mw, as;
        logic [3:0]  op;
        logic [4:0]  rdWb;
        logic        rwWb;
        logic [31:0] wbData;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] op1, op2, imm;
        logic        rw, mr, mw, as;
        logic [3:0]  op;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    id_ex_stage_if #(.XLEN(32), .CNT_W(2))  bus_b ();

    id_ex_stage #(.XLEN(32), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    id_ex_stage #(.XLEN(32), .CNT_W(2))  u_dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // Narrow-counter copy sees identical stimulus.
    assign bus_b.validId    = bus_a.validId;
    assign bus_b.pcId       = bus_a.pcId;
    assign bus_b.rs1Id      = bus_a.rs1Id;
    assign bus_b.rs2Id      = bus_a.rs2Id;
    assign bus_b.rdId       = bus_a.rdId;
    assign bus_b.useRs1Id   = bus_a.useRs1Id;
    assign bus_b.useRs2Id   = bus_a.useRs2Id;
    assign bus_b.rdata1Id   = bus_a.rdata1Id;
    assign bus_b.rdata2Id   = bus_a.rdata2Id;
    assign bus_b.immId      = bus_a.immId;
    assign bus_b.regWriteId = bus_a.regWriteId;
    assign bus_b.memReadId  = bus_a.memReadId;
    assign bus_b.memWriteId = bus_a.memWriteId;
    assign bus_b.aluSrcId   = bus_a.aluSrcId;
    assign bus_b.aluOpId    = bus_a.aluOpId;
    assign bus_b.rdWb       = bus_a.rdWb;
    assign bus_b.regWriteWb = bus_a.regWriteWb;
    assign bus_b.wbData     = bus_a.wbData;
    assign bus_b.flushEx    = bus_a.flushEx;

    int   passed = 0;
    int   total  = 0;
    exp_t exp_q[$];
    logic stall_q[$];

    // Reference model state: what EX should hold now, and load-use stalls since reset.
    exp_t        m;
    int unsigned stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        else passed++;
    endtask

    function automatic stim_t nop();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rst_n   = ($urandom_range(0, 99) != 0);
        s.validId = ($urandom_range(0, 9) != 0);
        s.pc      = $urandom;
        s.rs1     = 5'($urandom_range(0, 7));
        s.rs2     = 5'($urandom_range(0, 7));
        s.rd      = 5'($urandom_range(0, 7));
        s.u1      = ($urandom_range(0, 3) != 0);
        s.u2      = ($urandom_range(0, 3) != 0);
        s.rd1     = $urandom;
        s.rd2     = $urandom;
        s.imm     = $urandom;
        s.rw      = 1'($urandom_range(0, 1));
        s.mr      = 1'($urandom_range(0, 1));
        s.mw      = 1'($urandom_range(0, 1));
        s.as      = 1'($urandom_range(0, 1));
        s.op      = 4'($urandom_range(0, 15));
        s.rdWb    = 5'($urandom_range(0, 7));
        s.rwWb    = 1'($urandom_range(0, 1));
        s.wbData  = $urandom;
        s.flush   = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    function automatic logic [31:0] wb_val(input stim_t s, input logic [4:0] rs,
                                           input logic [31:0] rf);
        if (s.rwWb && s.rdWb != 5'd0 && s.rdWb == rs) return s.wbData;
        return rf;
    endfunction

    // Drive one cycle of stimulus and record what the stage must do with it.
    task automatic step(input stim_t s, output logic stalled);
        logic hz;
        exp_t nxt;
        @(negedge clk);
        rst_n              = s.rst_n;
        bus_a.validId      = s.validId;
        bus_a.pcId         = s.pc;
        bus_a.rs1Id        = s.rs1;
        bus_a.rs2Id        = s.rs2;
        bus_a.rdId         = s.rd;
        bus_a.useRs1Id     = s.u1;
        bus_a.useRs2Id     = s.u2;
        bus_a.rdata1Id     = s.rd1;
        bus_a.rdata2Id     = s.rd2;
        bus_a.immId        = s.imm;
        bus_a.regWriteId   = s.rw;
        bus_a.memReadId    = s.mr;
        bus_a.memWriteId   = s.mw;
        bus_a.aluSrcId     = s.as;
        bus_a.aluOpId      = s.op;
        bus_a.rdWb         = s.rdWb;
        bus_a.regWriteWb   = s.rwWb;
        bus_a.wbData       = s.wbData;
        bus_a.flushEx      = s.flush;
        #1;
        hz = s.rst_n && m.valid && m.mr && m.rd != 5'd0 && s.validId &&
             ((s.u1 && m.rd == s.rs1) || (s.u2 && m.rd == s.rs2));
        stalled = hz && !s.flush;
        stall_q.push_back(stalled);
        nxt = '0;
        if (!s.rst_n) begin
            stalls = 0;
        end else if (s.flush) begin
            nxt = '0;
        end else if (hz) begin
            stalls++;
        end else begin
            nxt.valid = s.validId;
            nxt.pc    = s.pc;
            nxt.rs1   = s.rs1;
            nxt.rs2   = s.rs2;
            nxt.rd    = s.rd;
            nxt.op1   = wb_val(s, s.rs1, s.rd1);
            nxt.op2   = wb_val(s, s.rs2, s.rd2);
            nxt.imm   = s.imm;
            nxt.rw    = s.validId && s.rw;
            nxt.mr    = s.validId && s.mr;
            nxt.mw    = s.validId && s.mw;
            nxt.as    = s.as;
            nxt.op    = s.op;
        end
        nxt.cnt  = (stalls > 65535) ? 16'hffff : 16'(stalls);
        nxt.cnt2 = (stalls > 3) ? 2'd3 : 2'(stalls);
        m = nxt;
        exp_q.push_back(nxt);
    endtask

    // Monitor: EX outputs one cycle after each stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("validEx",    64'(bus_a.validEx),    64'(e.valid));
                chk("pcEx",       64'(bus_a.pcEx),       64'(e.pc));
                chk("rs1Ex",      64'(bus_a.rs1Ex),      64'(e.rs1));
                chk("rs2Ex",      64'(bus_a.rs2Ex),      64'(e.rs2));
                chk("rdEx",       64'(bus_a.rdEx),       64'(e.rd));
                chk("op1Ex",      64'(bus_a.op1Ex),      64'(e.op1));
                chk("op2Ex",      64'(bus_a.op2Ex),      64'(e.op2));
                chk("immEx",      64'(bus_a.immEx),      64'(e.imm));
                chk("regWriteEx", 64'(bus_a.regWriteEx), 64'(e.rw));
                chk("memReadEx",  64'(bus_a.memReadEx),  64'(e.mr));
                chk("memWriteEx", 64'(bus_a.memWriteEx), 64'(e.mw));
                chk("aluSrcEx",   64'(bus_a.aluSrcEx),   64'(e.as));
                chk("aluOpEx",    64'(bus_a.aluOpEx),    64'(e.op));
                chk("stallCount", 64'(bus_a.stallCount), 64'(e.cnt));
                chk("sat_validEx",    64'(bus_b.validEx),    64'(e.valid));
                chk("sat_op1Ex",      64'(bus_b.op1Ex),      64'(e.op1));
                chk("sat_stallCount", 64'(bus_b.stallCount), 64'(e.cnt2));
            end
        end
    end

    // Monitor: combinational stallIf within the stimulus cycle.
    initial begin
        logic s;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                chk("stallIf",     64'(bus_a.stallIf), 64'(s));
                chk("sat_stallIf", 64'(bus_b.stallIf), 64'(s));
            end
        end
    end

    initial begin
        stim_t s, lw, add, cur, nx;
        logic  st;
        m      = '0;
        stalls = 0;

        // Reset with random ID activity.
        s = rnd_stim(); s.rst_n = 1'b0; step(s, st);
        s = rnd_stim(); s.rst_n = 1'b0; step(s, st);

        // ADD x3,x1,x2
        s = nop(); s.validId = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.u1 = 1; s.u2 = 1;
        s.rw = 1; s.rd1 = 32'h11; s.rd2 = 32'h22; s.pc = 32'h100; step(s, st);

        // LW x5 then dependent ADD x6,x5,x1 (stall once, then it issues)
        lw = nop(); lw.validId = 1; lw.rs1 = 2; lw.u1 = 1; lw.rd = 5; lw.rw = 1; lw.mr = 1;
        lw.as = 1; lw.imm = 32'h8;
        add = nop(); add.validId = 1; add.rs1 = 5; add.rs2 = 1; add.u1 = 1; add.u2 = 1;
        add.rd = 6; add.rw = 1; add.pc = 32'h204;
        step(lw, st); step(add, st); step(add, st);

        // No false stall: load to x0, and an unused rs2 match
        s = lw; s.rd = 0; step(s, st);
        s = add; s.rs1 = 0; step(s, st);
        step(lw, st);
        s = add; s.rs1 = 1; s.rs2 = 5; s.u2 = 0; step(s, st);

        // Flush beats load-use
        step(lw, st);
        s = add; s.flush = 1; step(s, st);

        // WB bypass on both operands, then none for x0
        s = nop(); s.validId = 1; s.rs1 = 7; s.rs2 = 7; s.u1 = 1; s.u2 = 1; s.rd = 8;
        s.rwWb = 1; s.rdWb = 7; s.wbData = 32'hDEADBEEF; step(s, st);
        s.rs1 = 0; s.rs2 = 0; s.rdWb = 0; s.rd1 = 32'h5; step(s, st);

        // Reset arriving mid-stall
        step(lw, st);
        s = add; s.rst_n = 0; step(s, st);
        step(nop(), st);

        // Randomised traffic; ID is held upstream while stalled.
        cur = rnd_stim();
        st  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            nx = rnd_stim();
            if (st) begin
                nx.validId = cur.validId; nx.pc = cur.pc; nx.rs1 = cur.rs1; nx.rs2 = cur.rs2;
                nx.rd = cur.rd; nx.u1 = cur.u1; nx.u2 = cur.u2; nx.rd1 = cur.rd1;
                nx.rd2 = cur.rd2; nx.imm = cur.imm; nx.rw = cur.rw; nx.mr = cur.mr;
                nx.mw = cur.mw; nx.as = cur.as; nx.op = cur.op;
            end
            step(nx, st);
            cur = nx;
        end

        step(nop(), st);
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drain", 64'(exp_q.size() + stall_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
